// File: rtl/ws2812b_driver.sv
// WS2812B single-wire NRZ driver: snapshots a frame on show, serialises it with
// 0/1 pulse timing, then holds the line low for the latch period.
module ws2812b_driver #(
  parameter int unsigned NUM_BITS = 12288,
  parameter int unsigned T_BIT    = 63,
  parameter int unsigned T0H      = 20,
  parameter int unsigned T1H      = 40,
  parameter int unsigned T_RESET  = 15000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                show,
  input  logic [NUM_BITS-1:0] signal,
  output logic                out
);

  localparam int unsigned CNT_MAX = (T_RESET > T_BIT) ? T_RESET : T_BIT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned IW      = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t              state;
  logic [NUM_BITS-1:0] frame;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt;
  logic                pending;

  logic [CW-1:0]       hi_len_c;
  logic [CW-1:0]       lo_len_c;
  logic                last_bit_c;

  // Pulse shape of the bit currently on the wire; frame is stable while it is sent.
  assign hi_len_c   = frame[idx] ? CW'(T1H) : CW'(T0H);
  assign lo_len_c   = CW'(T_BIT) - hi_len_c;
  assign last_bit_c = (idx == IW'(NUM_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      frame   <= '0;
      idx     <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out <= 1'b0;
          cnt <= '0;
          if (show) begin
            frame <= signal;
            idx   <= '0;
            out   <= 1'b1;
            state <= HIGH;
          end
        end

        HIGH: begin
          if (show) pending <= 1'b1;
          if (cnt == hi_len_c - CW'(1)) begin
            cnt   <= '0;
            out   <= 1'b0;
            state <= LOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        LOW: begin
          if (show) pending <= 1'b1;
          if (cnt == lo_len_c - CW'(1)) begin
            cnt <= '0;
            if (!last_bit_c) begin
              idx   <= idx + IW'(1);
              out   <= 1'b1;
              state <= HIGH;
            end else begin
              state <= LATCH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        LATCH: begin
          if (show) pending <= 1'b1;
          // A request seen on the final latch cycle counts as pending too.
          if (cnt == CW'(T_RESET - 1)) begin
            cnt <= '0;
            if (pending || show) begin
              pending <= 1'b0;
              frame   <= signal;
              idx     <= '0;
              out     <= 1'b1;
              state   <= HIGH;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          out   <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_driver.sv
// Bench for ws2812b_driver on a shortened chain; expected line waveform is
// built from the pulse-timing rules and compared cycle by cycle.
module tb_ws2812b_driver;

  localparam int unsigned NB    = 48;
  localparam int unsigned TBIT  = 63;
  localparam int unsigned TZH   = 20;
  localparam int unsigned TOH   = 40;
  localparam int unsigned TRST  = 300;
  localparam int unsigned FLEN  = NB * TBIT + TRST;

  logic          clk = 1'b0;
  logic          rst;
  logic          show;
  logic [NB-1:0] signal;
  logic          out;

  int n_cmp = 0;
  int n_err = 0;

  logic exp_q[$];

  ws2812b_driver #(
    .NUM_BITS(NB), .T_BIT(TBIT), .T0H(TZH), .T1H(TOH), .T_RESET(TRST)
  ) dut (
    .clk(clk), .rst(rst), .show(show), .signal(signal), .out(out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference waveform: each bit is its high time of ones then the remainder of
  // the bit period as zeros, followed by the latch gap.
  task automatic add_frame(input logic [NB-1:0] f);
    for (int b = 0; b < int'(NB); b++) begin
      int h;
      h = f[b] ? int'(TOH) : int'(TZH);
      for (int c = 0; c < int'(TBIT); c++) exp_q.push_back(c < h);
    end
    for (int c = 0; c < int'(TRST); c++) exp_q.push_back(1'b0);
  endtask

  task automatic add_idle(input int n);
    for (int c = 0; c < n; c++) exp_q.push_back(1'b0);
  endtask

  // Issue a show pulse, then compare every cycle of exp_q. show is additionally
  // driven high for cycle indices [sh_lo, sh_hi); signal becomes new_sig at chg_at.
  task automatic run(input string tag, input int sh_lo, input int sh_hi,
                     input int chg_at, input logic [NB-1:0] new_sig);
    int errs_before;
    errs_before = n_err;
    show = 1'b1;
    tick();
    for (int k = 0; k < exp_q.size(); k++) begin
      show = (k >= sh_lo) && (k < sh_hi);
      if (k == chg_at) signal = new_sig;
      if (n_err - errs_before < 8 || out !== exp_q[k])
        check($sformatf("%s[%0d]", tag, k), 32'(out), 32'(exp_q[k]));
      tick();
    end
    show = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [NB-1:0] rnd_frame();
    logic [NB-1:0] f;
    for (int i = 0; i < int'(NB); i += 32) f[i +: 16] = 16'($urandom);
    for (int i = 16; i < int'(NB); i += 32) f[i +: 16] = 16'($urandom);
    return f;
  endfunction

  initial begin
    logic [NB-1:0] f1, f2;
    rst = 1'b1; show = 1'b0; signal = '0;
    tick(); tick();
    check("reset_out", 32'(out), 32'h0);
    rst = 1'b0;

    // Idle with no show: line stays low.
    for (int k = 0; k < 200; k++) begin
      check($sformatf("idle[%0d]", k), 32'(out), 32'h0);
      tick();
    end

    // First pixel's G MSB only.
    f1 = '0; f1[0] = 1'b1;
    signal = f1;
    add_frame(f1); add_idle(20);
    run("first_bit", -1, -1, -1, f1);

    // Last bit only.
    f1 = '0; f1[NB-1] = 1'b1;
    signal = f1;
    add_frame(f1); add_idle(20);
    run("last_bit", -1, -1, -1, f1);

    // Random frames with a mid-frame data change that must not leak in.
    for (int r = 0; r < 3; r++) begin
      f1 = rnd_frame();
      f2 = ~f1;
      signal = f1;
      add_frame(f1); add_idle(20);
      run($sformatf("snap%0d", r), -1, -1, int'($urandom_range(10, NB * TBIT - 10)), f2);
    end

    // Show during frame with new data: two collapsed requests give one extra frame.
    f1 = rnd_frame(); f2 = rnd_frame();
    signal = f1;
    add_frame(f1); add_frame(f2); add_idle(30);
    run("pend_a", 1000, 1001, 1000, f2);
    signal = f1;
    exp_q.delete();
    add_frame(f1); add_frame(f2); add_idle(30);
    run("pend_b", 500, 501, 2000, f2);
    // second request at a different point, exercised through a separate pulse
    f1 = rnd_frame(); f2 = rnd_frame();
    signal = f1;
    add_frame(f1); add_frame(f2); add_idle(30);
    run("pend_latch", NB * TBIT + 100, NB * TBIT + 101, NB * TBIT + 50, f2);

    // Show held across the first frame into the second: three frames back to back.
    f1 = rnd_frame();
    signal = f1;
    add_frame(f1); add_frame(f1); add_frame(f1); add_idle(30);
    run("held", 0, FLEN + 10, -1, f1);

    // Reset mid-frame with a pending request: abort and stay idle.
    signal = rnd_frame();
    show = 1'b1;
    tick();
    show = 1'b0;
    for (int k = 0; k < 500; k++) begin
      show = (k == 200);
      tick();
    end
    show = 1'b0;
    check("pre_rst_active", 32'(1), 32'(1));
    rst = 1'b1;
    #1;
    check("rst_async_out", 32'(out), 32'h0);
    tick();
    rst = 1'b0;
    signal = rnd_frame();
    for (int k = 0; k < int'(FLEN) + 100; k++) begin
      if (out !== 1'b0 || k % 500 == 0)
        check($sformatf("post_rst[%0d]", k), 32'(out), 32'h0);
      tick();
    end

    // Normal frame after the abort.
    f1 = rnd_frame();
    signal = f1;
    add_frame(f1); add_idle(20);
    run("after_rst", -1, -1, -1, f1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
